// File: rtl/fire_indicator_frontend.sv
// fire_indicator_frontend
//   Sensor front end that builds the 2-bit fire_indicators bus.
//   Bit 0 is the smoke line after a 2-flop synchroniser and a debounce filter.
//   Bit 1 is the over-temperature flag. It uses hysteresis on strobed 8-bit
//   thermometer samples.
//   temp_fault flags a thermometer that has gone quiet for STALE_CYCLES cycles.
//   Optional feature macro: FIRE_SELFTEST_EN adds a 'selftest' input. While it
//   is high, fire_indicators is forced to 2'b11 one cycle later. The internal
//   state keeps running underneath.
module fire_indicator_frontend #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TEMP_ON         = 46,
  parameter int TEMP_HYST       = 3,
  parameter int STALE_CYCLES    = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       smoke_raw,
  input  logic       temp_valid,
  input  logic [7:0] temp_data,
`ifdef FIRE_SELFTEST_EN
  input  logic       selftest,
`endif
  output logic [1:0] fire_indicators,
  output logic       temp_fault
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ST_W = $clog2(STALE_CYCLES + 1);

  // The debounce counter toggles the output on the cycle it would reach
  // DEBOUNCE_CYCLES. It therefore never actually holds that value.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [DB_W-1:0] DB_ZERO = DB_W'(0);
  localparam logic [ST_W-1:0] ST_MAX  = ST_W'(STALE_CYCLES);
  localparam logic [ST_W-1:0] ST_ONE  = ST_W'(1);
  localparam logic [ST_W-1:0] ST_ZERO = ST_W'(0);
  localparam logic [7:0]      T_ON    = 8'(TEMP_ON);
  localparam logic [7:0]      T_OFF   = 8'(TEMP_ON - 1 - TEMP_HYST);

  logic            sync1_r;
  logic            sync2_r;
  logic            smoke_r;
  logic            temp_r;
  logic            temp_fault_r;
  logic [DB_W-1:0] db_cnt_r;
  logic [ST_W-1:0] stale_cnt_r;

  logic            smoke_nxt_s;
  logic            temp_nxt_s;
  logic            fault_nxt_s;
  logic [DB_W-1:0] db_cnt_nxt_s;
  logic [ST_W-1:0] stale_cnt_nxt_s;

  // Next-state logic for debounce, hysteresis and stale monitor
  always_comb begin
    smoke_nxt_s     = smoke_r;
    db_cnt_nxt_s    = DB_ZERO;
    temp_nxt_s      = temp_r;
    stale_cnt_nxt_s = stale_cnt_r;

    if (sync2_r != smoke_r) begin
      if (db_cnt_r >= DB_LAST) begin
        smoke_nxt_s  = ~smoke_r;
        db_cnt_nxt_s = DB_ZERO;
      end else begin
        db_cnt_nxt_s = db_cnt_r + DB_ONE;
      end
    end else begin
      db_cnt_nxt_s = DB_ZERO;
    end

    // Between the two thresholds the flag simply holds.
    if (temp_valid) begin
      if (temp_data >= T_ON) begin
        temp_nxt_s = 1'b1;
      end else if (temp_data <= T_OFF) begin
        temp_nxt_s = 1'b0;
      end else begin
        temp_nxt_s = temp_r;
      end
    end else begin
      temp_nxt_s = temp_r;
    end

    if (temp_valid) begin
      stale_cnt_nxt_s = ST_ZERO;
    end else if (stale_cnt_r >= ST_MAX) begin
      stale_cnt_nxt_s = ST_MAX;
    end else begin
      stale_cnt_nxt_s = stale_cnt_r + ST_ONE;
    end

    // Registered from the next count, so the fault matches the saturated counter
    fault_nxt_s = (stale_cnt_nxt_s == ST_MAX);
  end

  // State registers: synchroniser, filters, counters and fault flag
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r      <= 1'b0;
      sync2_r      <= 1'b0;
      smoke_r      <= 1'b0;
      temp_r       <= 1'b0;
      temp_fault_r <= 1'b0;
      db_cnt_r     <= DB_ZERO;
      stale_cnt_r  <= ST_ZERO;
    end else begin
      sync1_r      <= smoke_raw;
      sync2_r      <= sync1_r;
      smoke_r      <= smoke_nxt_s;
      temp_r       <= temp_nxt_s;
      temp_fault_r <= fault_nxt_s;
      db_cnt_r     <= db_cnt_nxt_s;
      stale_cnt_r  <= stale_cnt_nxt_s;
    end
  end

`ifdef FIRE_SELFTEST_EN
  logic [1:0] fire_out_r;

  // Output register: the self-test override sits on top of the true state
  always_ff @(posedge clk) begin
    if (rst) begin
      fire_out_r <= 2'b00;
    end else if (selftest) begin
      fire_out_r <= 2'b11;
    end else begin
      fire_out_r <= {temp_nxt_s, smoke_nxt_s};
    end
  end

  assign fire_indicators = fire_out_r;
`else
  assign fire_indicators = {temp_r, smoke_r};
`endif

  assign temp_fault = temp_fault_r;

endmodule

// File: tb/tb_fire_indicator_frontend.sv
// Testbench for fire_indicator_frontend.
// A behavioural model tracks the spec rules at every clock edge:
//   - the smoke bit changes once the synchronised line has disagreed with it
//     for DEB consecutive cycles;
//   - the temperature bit follows the threshold and hysteresis rules;
//   - the fault is "cycles since last strobe >= STALE".
// A negedge process compares the DUT with the model every cycle. Directed
// literal checks pin the model to hand-computed values.
module tb_fire_indicator_frontend;

  localparam int DEB   = 16;
  localparam int TON   = 46;
  localparam int THY   = 3;
  localparam int STALE = 1000;

  logic       clk;
  logic       rst;
  logic       smoke_raw;
  logic       temp_valid;
  logic [7:0] temp_data;
`ifdef FIRE_SELFTEST_EN
  logic       selftest;
`endif
  logic [1:0] fire_indicators;
  logic       temp_fault;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  // model state
  bit m_s1, m_s2, m_smoke, m_temp, m_fault, m_st;
  int m_run, m_since;
  logic [1:0] exp_fire;

  fire_indicator_frontend #(
    .DEBOUNCE_CYCLES(DEB), .TEMP_ON(TON), .TEMP_HYST(THY), .STALE_CYCLES(STALE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .smoke_raw(smoke_raw),
    .temp_valid(temp_valid),
    .temp_data(temp_data),
`ifdef FIRE_SELFTEST_EN
    .selftest(selftest),
`endif
    .fire_indicators(fire_indicators),
    .temp_fault(temp_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model, advanced on every rising edge
  always @(posedge clk) begin : model
    bit s2_old;
    s2_old = m_s2;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_smoke = 0; m_run = 0; m_temp = 0; m_since = 0;
    end else begin
      m_s2 = m_s1;
      m_s1 = smoke_raw;
      if (s2_old != m_smoke) begin
        m_run = m_run + 1;
        if (m_run >= DEB) begin
          m_smoke = ~m_smoke;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      if (temp_valid) begin
        if (int'(temp_data) >= TON) m_temp = 1;
        else if (int'(temp_data) <= TON - 1 - THY) m_temp = 0;
      end
      if (temp_valid) m_since = 0;
      else m_since = m_since + 1;
    end
    m_fault = (m_since >= STALE);
`ifdef FIRE_SELFTEST_EN
    m_st = rst ? 1'b0 : selftest;
`endif
    exp_fire = m_st ? 2'b11 : {m_temp, m_smoke};
  end

  // cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      tests = tests + 1;
      if (fire_indicators !== exp_fire || temp_fault !== m_fault) begin
        fails = fails + 1;
        $display("FAIL cycle_cmp t=%0t: fire=%b fault=%b, expected fire=%b fault=%b",
                 $time, fire_indicators, temp_fault, exp_fire, m_fault);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic strobe(input logic [7:0] v);
    temp_valid = 1'b1;
    temp_data  = v;
    tick();
    temp_valid = 1'b0;
  endtask

  task automatic smoke_latency(input string name);
    int first;
    first = 0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (fire_indicators[0] && first == 0) first = k;
    end
    check(name, first, 18);
  endtask

  initial begin
    bit silent;
    rst = 1'b1; smoke_raw = 1'b0; temp_valid = 1'b0; temp_data = 8'd0;
`ifdef FIRE_SELFTEST_EN
    selftest = 1'b0;
`endif
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    chk_en = 1;
    check("reset_fire", fire_indicators, 0);
    check("reset_fault", temp_fault, 0);

    // smoke debounce latency, release, and short glitch
    smoke_raw = 1'b1;
    smoke_latency("smoke_latency");
    smoke_raw = 1'b0;
    repeat (25) tick();
    check("smoke_release", fire_indicators[0], 0);
    smoke_raw = 1'b1;
    repeat (10) tick();
    smoke_raw = 1'b0;
    repeat (30) tick();
    check("glitch_10", fire_indicators[0], 0);

    // hysteresis
    strobe(8'd46);  check("hyst_46", fire_indicators[1], 1);
    strobe(8'd44);  check("hyst_44", fire_indicators[1], 1);
    strobe(8'd42);  check("hyst_42", fire_indicators[1], 0);
    strobe(8'd45);  check("hyst_45", fire_indicators[1], 0);
    strobe(8'd255); check("hyst_255", fire_indicators[1], 1);
    strobe(8'd43);  check("hyst_43", fire_indicators[1], 1);
    strobe(8'd0);   check("hyst_0", fire_indicators[1], 0);

    // stale monitor
    repeat (999) tick();
    check("stale_999", temp_fault, 0);
    tick();
    check("stale_1000", temp_fault, 1);
    repeat (5) tick();
    check("stale_hold", temp_fault, 1);
    strobe(8'd50);
    check("stale_clear", temp_fault, 0);
    check("stale_sample", fire_indicators[1], 1);

    // reset mid-debounce
    smoke_raw = 1'b1;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_fire", fire_indicators, 0);
    check("midrst_fault", temp_fault, 0);
    smoke_latency("midrst_latency");
    smoke_raw = 1'b0;
    repeat (25) tick();

`ifdef FIRE_SELFTEST_EN
    selftest = 1'b1;
    tick();
    check("selftest_on", fire_indicators, 3);
    selftest = 1'b0;
    tick();
    check("selftest_off", fire_indicators, 0);
`endif

    // randomized phase, with a long silent window to exercise the stale path
    for (int cyc = 0; cyc < 4000; cyc++) begin
      silent = (cyc >= 1500 && cyc < 2800);
      if ($urandom_range(0, 19) == 0) smoke_raw = ~smoke_raw;
      temp_valid = !silent && ($urandom_range(0, 7) == 0);
      temp_data  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(38, 50));
      rst = !silent && ($urandom_range(0, 599) == 0);
`ifdef FIRE_SELFTEST_EN
      if ($urandom_range(0, 99) == 0) selftest = ~selftest;
`endif
      tick();
    end
    rst = 1'b0;
    temp_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
